// File: rtl/execute_muldiv.sv
`default_nettype none
// ============================================================================
// Module      : execute_muldiv
// Description : Multi-cycle RV M-extension multiply/divide unit for the EX
//               stage. It takes one operation at a time and returns the result
//               with its tag and a one-cycle done pulse. Divide is restoring
//               radix-2; multiply is shift-add.
//               Optional macro MULDIV_FAST_MUL_EN makes multiplies single-cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module execute_muldiv #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             flush_i,
    input  logic             start_i,
    input  logic [2:0]       oper_i,
    input  logic [XLEN-1:0]  operand_a_i,
    input  logic [XLEN-1:0]  operand_b_i,
    input  logic [TAG_W-1:0] tag_i,
    output logic             ready_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [XLEN-1:0]  result_o,
    output logic [TAG_W-1:0] tag_o
);

    localparam int CNT_W = $clog2(XLEN) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t r_state, w_state_nxt;

    // r_hi/r_lo hold remainder/quotient (divide) or product high/low (multiply).
    // r_opd holds the divisor or multiplicand magnitude.
    logic [XLEN-1:0]  r_hi, r_lo, r_opd;
    logic [2:0]       r_op;
    logic [TAG_W-1:0] r_tag;
    logic             r_neg;
    logic [CNT_W-1:0] r_cnt;
    logic [XLEN-1:0]  r_result;
    logic [TAG_W-1:0] r_tag_out;
    logic             r_done;

    // Operand decode at acceptance
    logic            w_is_div, w_sign_a, w_sign_b, w_neg_a, w_neg_b;
    logic [XLEN-1:0] w_mag_a, w_mag_b;
    logic            w_div_zero, w_div_ovf, w_special, w_fast_mul, w_accept;

    assign w_is_div   = oper_i[2];
    assign w_sign_a   = (oper_i == 3'd1) | (oper_i == 3'd2) | (oper_i == 3'd4) | (oper_i == 3'd6);
    assign w_sign_b   = (oper_i == 3'd1) | (oper_i == 3'd4) | (oper_i == 3'd6);
    assign w_neg_a    = w_sign_a & operand_a_i[XLEN-1];
    assign w_neg_b    = w_sign_b & operand_b_i[XLEN-1];
    assign w_mag_a    = w_neg_a ? -operand_a_i : operand_a_i;
    assign w_mag_b    = w_neg_b ? -operand_b_i : operand_b_i;
    assign w_div_zero = w_is_div & (operand_b_i == '0);
    assign w_div_ovf  = w_is_div & ~oper_i[0]
                      & (operand_a_i == {1'b1, {(XLEN-1){1'b0}}})
                      & (operand_b_i == '1);
    assign w_special  = w_div_zero | w_div_ovf;
    assign w_accept   = start_i & ready_o & ~flush_i;

`ifdef MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] w_fast_prod;
    assign w_fast_mul  = ~w_is_div;
    assign w_fast_prod = {{XLEN{1'b0}}, w_mag_a} * {{XLEN{1'b0}}, w_mag_b};
`else
    assign w_fast_mul  = 1'b0;
`endif

    // One iteration step for each algorithm
    logic [XLEN:0] w_div_shift, w_div_sub, w_mul_add;
    logic          w_div_ge;

    assign w_div_shift = {r_hi, r_lo[XLEN-1]};
    assign w_div_sub   = w_div_shift - {1'b0, r_opd};
    assign w_div_ge    = ~w_div_sub[XLEN];
    assign w_mul_add   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opd} : {(XLEN+1){1'b0}});

    // Sign correction and output half selection
    logic [2*XLEN-1:0] w_prod_s;
    logic [XLEN-1:0]   w_quo_s, w_rem_s, w_result;

    assign w_prod_s = r_neg ? -{r_hi, r_lo} : {r_hi, r_lo};
    assign w_quo_s  = r_neg ? -r_lo : r_lo;
    assign w_rem_s  = r_neg ? -r_hi : r_hi;

    // Pick the architectural result for the latched operation
    always_comb begin
        w_result = w_prod_s[2*XLEN-1:XLEN];
        if (r_op[2])
            w_result = r_op[1] ? w_rem_s : w_quo_s;
        else if (r_op[1:0] == 2'd0)
            w_result = w_prod_s[XLEN-1:0];
    end

    // State register
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    // Next-state logic; flush overrides every transition
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start_i) w_state_nxt = (w_special | w_fast_mul) ? S_FIX : S_CALC;
            S_CALC:  if (r_cnt == '0) w_state_nxt = S_FIX;
            S_FIX:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        if (flush_i) w_state_nxt = S_IDLE;
    end

    // Datapath: latch on accept, iterate in CALC, register result in FIX
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_hi      <= '0;
            r_lo      <= '0;
            r_opd     <= '0;
            r_op      <= '0;
            r_tag     <= '0;
            r_neg     <= 1'b0;
            r_cnt     <= '0;
            r_result  <= '0;
            r_tag_out <= '0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (flush_i) begin
                r_cnt <= '0;
            end else if (w_accept) begin
                r_op  <= oper_i;
                r_tag <= tag_i;
                r_cnt <= CNT_W'(XLEN - 1);
                r_hi  <= '0;
                if (w_div_zero) begin
                    r_lo  <= '1;
                    r_hi  <= operand_a_i;
                    r_neg <= 1'b0;
                end else if (w_div_ovf) begin
                    r_lo  <= operand_a_i;
                    r_neg <= 1'b0;
                end else if (w_is_div) begin
                    r_lo  <= w_mag_a;
                    r_opd <= w_mag_b;
                    r_neg <= oper_i[1] ? w_neg_a : (w_neg_a ^ w_neg_b);
                end else begin
                    r_lo  <= w_mag_b;
                    r_opd <= w_mag_a;
                    r_neg <= w_neg_a ^ w_neg_b;
`ifdef MULDIV_FAST_MUL_EN
                    {r_hi, r_lo} <= w_fast_prod;
`endif
                end
            end else if (r_state == S_CALC) begin
                r_cnt <= r_cnt - CNT_W'(1);
                if (r_op[2]) begin
                    r_hi <= w_div_ge ? w_div_sub[XLEN-1:0] : w_div_shift[XLEN-1:0];
                    r_lo <= {r_lo[XLEN-2:0], w_div_ge};
                end else begin
                    {r_hi, r_lo} <= {w_mul_add, r_lo[XLEN-1:1]};
                end
            end else if (r_state == S_FIX) begin
                r_result  <= w_result;
                r_tag_out <= r_tag;
                r_done    <= 1'b1;
            end
        end
    end

    assign ready_o  = (r_state == S_IDLE);
    assign busy_o   = ~ready_o;
    assign done_o   = r_done;
    assign result_o = r_result;
    assign tag_o    = r_tag_out;

endmodule
`default_nettype wire

// File: tb/tb_execute_muldiv.sv
`default_nettype none
// ============================================================================
// Module      : tb_execute_muldiv
// Description : Self-checking bench for execute_muldiv (XLEN=32). Expected
//               results are queued at issue and compared on done_o.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_execute_muldiv;

    localparam int XLEN  = 32;
    localparam int TAG_W = 5;
`ifdef MULDIV_FAST_MUL_EN
    localparam int C_MUL_LAT = 1;
`else
    localparam int C_MUL_LAT = 33;
`endif
    localparam int C_DIV_LAT = 33;

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic             flush = 1'b0;
    logic             start = 1'b0;
    logic [2:0]       oper = '0;
    logic [XLEN-1:0]  opa = '0;
    logic [XLEN-1:0]  opb = '0;
    logic [TAG_W-1:0] tg = '0;
    logic             ready, busy, done;
    logic [XLEN-1:0]  result;
    logic [TAG_W-1:0] tag_out;

    int n_cmp = 0;
    int n_err = 0;
    logic [XLEN+TAG_W-1:0] sb_q[$];
    logic [XLEN+TAG_W-1:0] sb_e;

    execute_muldiv #(.XLEN(XLEN), .TAG_W(TAG_W)) u_dut (
        .clk_i      (clk),
        .rstn_i     (rstn),
        .flush_i    (flush),
        .start_i    (start),
        .oper_i     (oper),
        .operand_a_i(opa),
        .operand_b_i(opb),
        .tag_i      (tag_out_dummy()),
        .ready_o    (ready),
        .busy_o     (busy),
        .done_o     (done),
        .result_o   (result),
        .tag_o      (tag_out)
    );

    function automatic logic [TAG_W-1:0] tag_out_dummy();
        return tg;
    endfunction

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, obs, exp, $time);
        end
    endtask

    // Scoreboard: every done pulse must match the oldest outstanding op
    always @(negedge clk) begin
        if (rstn && done) begin
            if (sb_q.size() == 0) begin
                check("spurious_done", 64'(done), 64'(0));
            end else begin
                sb_e = sb_q.pop_front();
                check("result", 64'(result), 64'(sb_e[XLEN+TAG_W-1:TAG_W]));
                check("tag", 64'(tag_out), 64'(sb_e[TAG_W-1:0]));
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!ready && n < 100) begin
            @(posedge clk); #1; n++;
        end
        check("ready_before_start", 64'(ready), 64'(1));
    endtask

    // Issue one op and wait (bounded) for its done pulse.
    // Expects to be called 1 time unit after a rising edge.
    task automatic run_op(input logic [2:0] op, input logic [XLEN-1:0] a,
                          input logic [XLEN-1:0] b, input logic [TAG_W-1:0] t,
                          input logic [XLEN-1:0] exp, input int lat, input bit poke);
        int n;
        wait_ready();
        sb_q.push_back({exp, t});
        oper = op; opa = a; opb = b; tg = t; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        opa = $urandom; opb = $urandom; oper = 3'($urandom); tg = 5'($urandom);
        check("busy_after_accept", 64'(busy), 64'(1));
        n = 0;
        while (!done && n < 100) begin
            if (poke && n == 4) begin
                start = 1'b1; oper = 3'd0; opa = 32'd3; opb = 32'd3; tg = 5'd31;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1; n++;
        end
        start = 1'b0;
        check("latency", 64'(n), 64'(lat));
        check("ready_in_done", 64'(ready), 64'(1));
        if (!done) sb_q.delete();
    endtask

    initial begin
        #12;
        check("rst_ready", 64'(ready), 64'(1));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_result", 64'(result), 64'(0));
        check("rst_tag", 64'(tag_out), 64'(0));
        @(negedge clk); rstn = 1'b1;
        @(posedge clk); #1;

        // Signed divide / remainder
        run_op(3'd4, 32'hFFFFFFF9, 32'd2, 5'd5, 32'hFFFFFFFD, C_DIV_LAT, 1'b0);
        run_op(3'd6, 32'hFFFFFFF9, 32'd2, 5'd6, 32'hFFFFFFFF, C_DIV_LAT, 1'b0);
        run_op(3'd4, 32'd7, 32'hFFFFFFFE, 5'd7, 32'hFFFFFFFD, C_DIV_LAT, 1'b0);
        run_op(3'd6, 32'd7, 32'hFFFFFFFE, 5'd8, 32'h00000001, C_DIV_LAT, 1'b0);
        // Divide by zero and overflow take the short path
        run_op(3'd5, 32'h12345678, 32'd0, 5'd9, 32'hFFFFFFFF, 1, 1'b0);
        run_op(3'd7, 32'd5, 32'd0, 5'd10, 32'h00000005, 1, 1'b0);
        run_op(3'd4, 32'hFFFFFFFB, 32'd0, 5'd11, 32'hFFFFFFFF, 1, 1'b0);
        run_op(3'd6, 32'hFFFFFFFB, 32'd0, 5'd12, 32'hFFFFFFFB, 1, 1'b0);
        run_op(3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd13, 32'h80000000, 1, 1'b0);
        run_op(3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd14, 32'h00000000, 1, 1'b0);
        // Multiplies
        run_op(3'd0, 32'hFFFFFFFF, 32'd2, 5'd15, 32'hFFFFFFFE, C_MUL_LAT, 1'b0);
        run_op(3'd1, 32'h80000000, 32'h80000000, 5'd16, 32'h40000000, C_MUL_LAT, 1'b0);
        run_op(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd17, 32'hFFFFFFFF, C_MUL_LAT, 1'b0);
        run_op(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd18, 32'hFFFFFFFE, C_MUL_LAT, 1'b0);
        run_op(3'd0, 32'hFFFFFFFD, 32'd5, 5'd19, 32'hFFFFFFF1, C_MUL_LAT, 1'b0);
        run_op(3'd1, 32'hFFFFFFFD, 32'd5, 5'd20, 32'hFFFFFFFF, C_MUL_LAT, 1'b0);

        // Flush at edge k+10: no done pulse, unit idle again
        wait_ready();
        oper = 3'd5; opa = 32'd100; opb = 32'd7; tg = 5'd21; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(posedge clk); #1; flush = 1'b0;
        check("flush_ready", 64'(ready), 64'(1));
        check("flush_done", 64'(done), 64'(0));
        repeat (40) begin @(posedge clk); #1; end
        check("flush_result_kept", 64'(result), 64'(32'hFFFFFFFF));

        // Restart after flush, with a start pulse while busy
        run_op(3'd5, 32'd100, 32'd7, 5'd22, 32'd14, C_DIV_LAT, 1'b1);
        run_op(3'd7, 32'd100, 32'd7, 5'd23, 32'd2, C_DIV_LAT, 1'b0);

        // Asynchronous reset mid-CALC
        wait_ready();
        oper = 3'd4; opa = 32'd100; opb = 32'd7; tg = 5'd24; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (10) begin @(posedge clk); #1; end
        #2 rstn = 1'b0;
        #1;
        check("arst_ready", 64'(ready), 64'(1));
        check("arst_busy", 64'(busy), 64'(0));
        check("arst_done", 64'(done), 64'(0));
        check("arst_result", 64'(result), 64'(0));
        check("arst_tag", 64'(tag_out), 64'(0));
        @(negedge clk); rstn = 1'b1;
        @(posedge clk); #1;
        check("arst_release_ready", 64'(ready), 64'(1));
        repeat (40) begin @(posedge clk); #1; end
        check("arst_no_done", 64'(done), 64'(0));

        // Back-to-back: second op issued in the done cycle of the first
        run_op(3'd5, 32'd1000, 32'd10, 5'd25, 32'd100, C_DIV_LAT, 1'b0);
        check("b2b_done_cycle", 64'(done), 64'(1));
        run_op(3'd5, 32'hFFFFFFFF, 32'd3, 5'd26, 32'h55555555, C_DIV_LAT, 1'b0);
        run_op(3'd3, 32'h00010000, 32'h00010000, 5'd27, 32'h00000001, C_MUL_LAT, 1'b0);

        repeat (5) begin @(posedge clk); #1; end
        check("scoreboard_empty", 64'(sb_q.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
